wb_trace_buffer: RTL and testbench

Synthesisable commit-trace capture buffer for the pipeline CPU. It records each register writeback (PC, destination register, data, optional timestamp) into a parametrised circular buffer. Entries drain through a valid/ready read port to a debug/UART host or a bench scoreboard. It replaces ad-hoc printing of the PC, rd and writeback data with an in-design, depth-limited log that has stop-on-full and wrap-overwrite modes.

---
 rtl/wb_trace_buffer.sv | 157 +++++++++++++++
 tb/tb_wb_trace_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace_buffer
//  Description : Commit-trace capture buffer. Records register writebacks
//                (PC, rd, data, optional timestamp) into a circular buffer
//                and drains them through a first-word-fall-through
//                valid/ready read port. Supports stop-on-full and
//                overwrite-oldest modes with a sticky overflow flag and a
//                saturating dropped-entry counter.
//                Optional macro WBTRACE_TSTAMP_EN adds a free-running
//                32-bit cycle counter stored with each entry (rd_tstamp).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 16,
    parameter int SKIP_X0 = 1,
    parameter int DROP_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic [REG_AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     capture_en,
    input  logic                     mode_wrap,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [REG_AW-1:0]        rd_rd,
    output logic [XLEN-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
`ifdef WBTRACE_TSTAMP_EN
    output logic [31:0]              rd_tstamp,
`endif
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL     = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]     c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
    localparam logic [DROP_W-1:0] c_DROP_ONE = DROP_W'(1);
    localparam logic              c_SKIP     = (SKIP_X0 != 0);

    // Storage array (not reset; contents are don't-care until written)
    logic [XLEN-1:0]   r_mem_pc   [DEPTH];
    logic [REG_AW-1:0] r_mem_rd   [DEPTH];
    logic [XLEN-1:0]   r_mem_data [DEPTH];
`ifdef WBTRACE_TSTAMP_EN
    logic [31:0]       r_mem_ts   [DEPTH];
    logic [31:0]       r_tstamp;
`endif

    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_push_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_drop;
    logic w_radv;

    // A push that cannot be stored either overwrites the head (wrap mode)
    // or is discarded; both count as a drop. clear suppresses everything.
    assign w_push_req = wb_valid & capture_en & ~(c_SKIP & (wb_rd == '0));
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = ~w_empty & rd_ready;
    assign w_write    = w_push_req & (~w_full | w_pop | mode_wrap) & ~clear;
    assign w_drop     = w_push_req & w_full & ~w_pop & ~clear;
    assign w_radv     = w_pop | (w_drop & mode_wrap);

    // Pointer, occupancy and overflow bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_radv) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            // Occupancy only moves on an unmatched push into free space or
            // an unmatched pop; overwrite and push+pop leave it unchanged.
            if (w_write && !w_full && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
                end
            end
        end
    end

    // Entry write into the storage array at the write pointer
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_pc[r_wptr]   <= wb_pc;
            r_mem_rd[r_wptr]   <= wb_rd;
            r_mem_data[r_wptr] <= wb_data;
`ifdef WBTRACE_TSTAMP_EN
            r_mem_ts[r_wptr]   <= r_tstamp;
`endif
        end
    end

`ifdef WBTRACE_TSTAMP_EN
    // Free-running cycle counter; the value at the push edge is stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tstamp <= '0;
        end else if (clear) begin
            r_tstamp <= '0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end

    assign rd_tstamp = r_mem_ts[r_rptr];
`endif

    // First-word-fall-through read port straight from the array
    assign rd_valid = ~w_empty;
    assign rd_pc    = r_mem_pc[r_rptr];
    assign rd_rd    = r_mem_rd[r_rptr];
    assign rd_data  = r_mem_data[r_rptr];
    assign count    = r_count;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_trace_buffer
//  Description : Self-checking bench for wb_trace_buffer. A queue-based
//                model tracks the expected buffer contents; literal checks
//                pin the model at key points of the directed sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_buffer;

    localparam int DEPTH    = 16;
    localparam int DROP_W   = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        capture_en;
    logic        mode_wrap;
    logic        clear;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [DROP_W-1:0] drop_cnt;
`ifdef WBTRACE_TSTAMP_EN
    logic [31:0] rd_tstamp;
`endif

    int nvec = 0;
    int nmis = 0;

    wb_trace_buffer #(
        .XLEN    (32),
        .REG_AW  (5),
        .DEPTH   (DEPTH),
        .SKIP_X0 (1),
        .DROP_W  (DROP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .capture_en (capture_en),
        .mode_wrap  (mode_wrap),
        .clear      (clear),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_pc      (rd_pc),
        .rd_rd      (rd_rd),
        .rd_data    (rd_data),
        .count      (count),
        .overflow   (overflow),
`ifdef WBTRACE_TSTAMP_EN
        .rd_tstamp  (rd_tstamp),
`endif
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] ts;
    } ent_t;

    ent_t        mq[$];
    logic        movf;
    int          mdrop;
    logic [31:0] mts;
    ent_t        me;
    logic        mpush;
    logic        mpop;
    logic        mfull;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            movf  = 1'b0;
            mdrop = 0;
            mts   = 32'd0;
        end else if (clear) begin
            mq.delete();
            movf  = 1'b0;
            mdrop = 0;
            mts   = 32'd0;
        end else begin
            mpush = wb_valid && capture_en && (wb_rd != 5'd0);
            mpop  = (mq.size() != 0) && rd_ready;
            mfull = (mq.size() == DEPTH);
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                me.pc = wb_pc; me.rd = wb_rd; me.data = wb_data; me.ts = mts;
                if (!mfull || mpop) begin
                    mq.push_back(me);
                end else begin
                    movf = 1'b1;
                    if (mdrop < DROP_MAX) mdrop++;
                    if (mode_wrap) begin
                        void'(mq.pop_front());
                        mq.push_back(me);
                    end
                end
            end
            mts = mts + 32'd1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            check("m_valid", {63'd0, rd_valid}, {63'd0, (mq.size() != 0)});
            check("m_count", {59'd0, count}, 64'(mq.size()));
            check("m_overflow", {63'd0, overflow}, {63'd0, movf});
            check("m_drop", {60'd0, drop_cnt}, 64'(mdrop));
            if (mq.size() != 0) begin
                check("m_pc", {32'd0, rd_pc}, {32'd0, mq[0].pc});
                check("m_rd", {59'd0, rd_rd}, {59'd0, mq[0].rd});
                check("m_data", {32'd0, rd_data}, {32'd0, mq[0].data});
`ifdef WBTRACE_TSTAMP_EN
                check("m_tstamp", {32'd0, rd_tstamp}, {32'd0, mq[0].ts});
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] data, input logic rdy, input logic clr);
        wb_valid = v; wb_pc = pc; wb_rd = rd; wb_data = data;
        rd_ready = rdy; clear = clr;
        @(posedge clk);
        #1;
        wb_valid = 1'b0; rd_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++)
            step(1'b1, 32'(4 * (base + i)), 5'((i % 31) + 1), 32'(base + i), 1'b0, 1'b0);
    endtask

    logic [31:0] exp3 [3];

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_rd = '0; wb_data = '0;
        capture_en = 1'b1; mode_wrap = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        exp3[0] = 32'h11; exp3[1] = 32'h22; exp3[2] = 32'h33;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_count", {59'd0, count}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_drop", {60'd0, drop_cnt}, 64'd0);
        reset = 1'b0;

        // Basic FIFO order
        step(1'b1, 32'h0, 5'd1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h4, 5'd2, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h8, 5'd3, 32'h33, 1'b0, 1'b0);
        check("t1_count", {59'd0, count}, 64'd3);
        check("t1_valid", {63'd0, rd_valid}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("t1_head_pc", {32'd0, rd_pc}, 64'(4 * i));
            check("t1_head_rd", {59'd0, rd_rd}, 64'(i + 1));
            check("t1_head_data", {32'd0, rd_data}, {32'd0, exp3[i]});
            step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        check("t1_empty_valid", {63'd0, rd_valid}, 64'd0);
        check("t1_empty_count", {59'd0, count}, 64'd0);

        // x0 skip and capture gate
        step(1'b1, 32'h10, 5'd0, 32'hDEAD, 1'b0, 1'b0);
        step(1'b1, 32'h14, 5'd5, 32'h55, 1'b0, 1'b0);
        check("t2_count", {59'd0, count}, 64'd1);
        check("t2_head_rd", {59'd0, rd_rd}, 64'd5);
        capture_en = 1'b0;
        step(1'b1, 32'h18, 5'd6, 32'h66, 1'b0, 1'b0);
        check("t2_gated_count", {59'd0, count}, 64'd1);
        capture_en = 1'b1;
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);

        // Stop-on-full
        fill(18, 1);
        check("t3_count", {59'd0, count}, 64'd16);
        check("t3_overflow", {63'd0, overflow}, 64'd1);
        check("t3_drop", {60'd0, drop_cnt}, 64'd2);
        for (int i = 1; i <= 16; i++) begin
            check("t3_drain", {32'd0, rd_data}, 64'(i));
            step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        check("t3_empty", {63'd0, rd_valid}, 64'd0);
        check("t3_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Drop counter saturation
        fill(16, 50);
        fill(20, 70);
        check("sat_drop", {60'd0, drop_cnt}, 64'd15);
        // clear discards a simultaneous push
        step(1'b1, 32'h100, 5'd7, 32'h77, 1'b0, 1'b1);
        check("clr_count", {59'd0, count}, 64'd0);
        check("clr_overflow", {63'd0, overflow}, 64'd0);
        check("clr_drop", {60'd0, drop_cnt}, 64'd0);

        // Overwrite-oldest
        mode_wrap = 1'b1;
        fill(18, 1);
        check("t4_count", {59'd0, count}, 64'd16);
        check("t4_overflow", {63'd0, overflow}, 64'd1);
        check("t4_drop", {60'd0, drop_cnt}, 64'd2);
        for (int i = 3; i <= 18; i++) begin
            check("t4_drain", {32'd0, rd_data}, 64'(i));
            step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        step(1'b1, 32'h400, 5'd9, 32'd100, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            check("t4_pair_head", {32'd0, rd_data}, 64'(100 + k));
            step(1'b1, 32'(1024 + 4 * k), 5'd9, 32'(101 + k), 1'b1, 1'b0);
        end
        check("t4_pair_count", {59'd0, count}, 64'd1);
        check("t4_pair_last", {32'd0, rd_data}, 64'd140);
        mode_wrap = 1'b0;

        // Full with simultaneous push and pop
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        fill(16, 200);
        check("t5_head_before", {32'd0, rd_data}, 64'd200);
        step(1'b1, 32'h500, 5'd4, 32'd300, 1'b1, 1'b0);
        check("t5_count", {59'd0, count}, 64'd16);
        check("t5_overflow", {63'd0, overflow}, 64'd0);
        check("t5_head_after", {32'd0, rd_data}, 64'd201);
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        rd_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", {63'd0, rd_valid}, 64'd0);
        check("t5_async_count", {59'd0, count}, 64'd0);
        rd_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef WBTRACE_TSTAMP_EN
        idle();
        idle();
        step(1'b1, 32'h600, 5'd1, 32'hA, 1'b0, 1'b0);
        repeat (4) idle();
        step(1'b1, 32'h604, 5'd2, 32'hB, 1'b0, 1'b0);
        check("ts_first", {32'd0, rd_tstamp}, 64'd2);
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("ts_second", {32'd0, rd_tstamp}, 64'd7);
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("ts_clr_count", {59'd0, count}, 64'd0);
        check("ts_clr_overflow", {63'd0, overflow}, 64'd0);
        step(1'b1, 32'h608, 5'd3, 32'hC, 1'b0, 1'b0);
        check("ts_after_clear", {32'd0, rd_tstamp}, 64'd0);
`endif

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
